// File: rtl/cnn_mac_pkg.sv
// rtl/cnn_mac_pkg.sv - shared widths and FSM encoding for the sequential MAC
package cnn_mac_pkg;

    localparam int CNN_A_W   = 14;
    localparam int CNN_B_W   = 8;
    localparam int CNN_LEN_W = 8;
    localparam int CNN_ACC_W = CNN_A_W + CNN_B_W + CNN_LEN_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_t;

endpackage

// File: rtl/cnn_mac_mul_reg.sv
// rtl/cnn_mac_mul_reg.sv - registered signed multiplier with enable and valid flag
module cnn_mac_mul_reg
    import cnn_mac_pkg::*;
#(
    parameter int A_W = CNN_A_W,
    parameter int B_W = CNN_B_W,
    parameter int P_W = A_W + B_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  en,
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic signed [P_W-1:0] p,
    output logic                  p_vld
);

    logic signed [P_W-1:0] p_d, p_q;
    logic                  p_vld_d, p_vld_q;

    // Capture the full-precision product only on an accepted pair; flag it for one cycle
    always_comb begin
        p_d     = p_q;
        p_vld_d = en;
        if (en) begin
            p_d = P_W'(a) * P_W'(b);
        end
    end

    // Product and valid registers
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            p_q     <= '0;
            p_vld_q <= 1'b0;
        end else begin
            p_q     <= p_d;
            p_vld_q <= p_vld_d;
        end
    end

    assign p     = p_q;
    assign p_vld = p_vld_q;

endmodule

// File: rtl/cnn_mac_seq.sv
// rtl/cnn_mac_seq.sv - sequential dot-product engine: FSM, tap counter, accumulator
module cnn_mac_seq
    import cnn_mac_pkg::*;
#(
    parameter int A_W   = CNN_A_W,
    parameter int B_W   = CNN_B_W,
    parameter int LEN_W = CNN_LEN_W,
    parameter int ACC_W = A_W + B_W + LEN_W
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    output logic                    idle,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [A_W-1:0]   a_data,
    input  logic signed [B_W-1:0]   b_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] acc_out
);

    localparam int P_W = A_W + B_W;

    mac_state_t              state_d, state_q;
    logic [LEN_W-1:0]        cnt_d, cnt_q;
    logic [LEN_W-1:0]        len_d, len_q;
    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic signed [P_W-1:0]   p_reg;
    logic                    p_vld;
    logic                    accept;
    logic [LEN_W-1:0]        cnt_inc;

    assign accept  = in_valid && in_ready;
    assign cnt_inc = cnt_q + LEN_W'(1);

    cnn_mac_mul_reg #(
        .A_W (A_W),
        .B_W (B_W),
        .P_W (P_W)
    ) u_mul (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .en     (accept),
        .a      (a_data),
        .b      (b_data),
        .p      (p_reg),
        .p_vld  (p_vld)
    );

    // Next-state, counter, accumulator and handshake outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        acc_d     = acc_q;
        idle      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        // A registered product is folded in the cycle after its multiply
        if (p_vld) begin
            acc_d = acc_q + ACC_W'(p_reg);
        end

        case (state_q)
            ST_IDLE: begin
                idle = 1'b1;
                if (start) begin
                    acc_d = '0;
                    cnt_d = '0;
                    if (len != '0) begin
                        len_d   = len;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Last product lands in the accumulator this cycle
                state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, latched length and accumulator registers
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
        end
    end

    assign acc_out = acc_q;

endmodule

// File: tb/tb_cnn_mac_seq.sv
// tb/tb_cnn_mac_seq.sv - directed table-driven bench for cnn_mac_seq
module tb_cnn_mac_seq;

    logic               ap_clk;
    logic               ap_rst;
    logic               start;
    logic [7:0]         len;
    logic               idle;
    logic               in_valid;
    logic               in_ready;
    logic signed [13:0] a_data;
    logic signed [7:0]  b_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [29:0] acc_out;

    int n_pass;
    int n_total;

    typedef struct packed {
        logic [31:0]       l;
        logic [3:0][13:0]  a;
        logic [3:0][7:0]   b;
        logic [31:0]       exp;
    } vec_t;

    vec_t vecs[5];

    cnn_mac_seq dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .start     (start),
        .len       (len),
        .idle      (idle),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_data    (a_data),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic vec_t mk(input int l,
                                input int a0, input int b0, input int a1, input int b1,
                                input int a2, input int b2, input int a3, input int b3,
                                input int e);
        vec_t v;
        v.l    = l;
        v.a[0] = a0[13:0]; v.b[0] = b0[7:0];
        v.a[1] = a1[13:0]; v.b[1] = b1[7:0];
        v.a[2] = a2[13:0]; v.b[2] = b2[7:0];
        v.a[3] = a3[13:0]; v.b[3] = b3[7:0];
        v.exp  = e;
        return v;
    endfunction

    // Streams l pairs back-to-back and stops once out_valid rises
    task automatic run_to_done(input int l, input logic [3:0][13:0] av,
                               input logic [3:0][7:0] bv, input string nm);
        int lat;
        start = 1'b1;
        len   = l[7:0];
        step();
        start = 1'b0;
        for (int i = 0; i < l; i++) begin
            a_data   = av[i];
            b_data   = bv[i];
            in_valid = 1'b1;
            check({nm, "_in_ready"}, longint'(in_ready), 1);
            step();
        end
        in_valid = 1'b0;
        check({nm, "_drain_ready"}, longint'(in_ready), 0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({nm, "_latency"}, lat, 2);
    endtask

    task automatic handshake(input string nm);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({nm, "_idle_after"}, longint'(idle), 1);
    endtask

    initial begin
        int    accepts;
        int    cyc;
        logic  stable;
        logic  [3:0][13:0] av;
        logic  [3:0][7:0]  bv;

        n_pass    = 0;
        n_total   = 0;
        ap_rst    = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        a_data    = '0;
        b_data    = '0;
        out_ready = 1'b0;

        vecs[0] = mk(3, 100, 2, -8192, -128, 8191, 127, 0, 0, 2089033);
        vecs[1] = mk(1, 3, -5, 0, 0, 0, 0, 0, 0, -15);
        vecs[2] = mk(2, -8192, 127, 8191, -128, 0, 0, 0, 0, -2088832);
        vecs[3] = mk(4, 1, 1, 2, -2, -3, 3, 4, -4, -28);
        vecs[4] = mk(2, 0, -128, -1, -1, 0, 0, 0, 0, 1);

        step();
        step();
        check("rst_idle", longint'(idle), 1);
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_acc", longint'(acc_out), 0);
        ap_rst = 1'b0;
        step();

        for (int k = 0; k < 5; k++) begin
            run_to_done(int'(vecs[k].l), vecs[k].a, vecs[k].b, $sformatf("vec%0d", k));
            check($sformatf("vec%0d_acc", k), longint'(acc_out), longint'($signed(vecs[k].exp)));
            handshake($sformatf("vec%0d", k));
        end

        // len=255, every pair at the extreme, in_valid toggling
        accepts = 0;
        cyc     = 0;
        start   = 1'b1;
        len     = 8'd255;
        step();
        start   = 1'b0;
        a_data  = -14'sd8192;
        b_data  = -8'sd128;
        while (!out_valid && cyc < 2000) begin
            in_valid = cyc[0] == 1'b0;
            if (in_valid && in_ready) accepts++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("long_done", longint'(out_valid), 1);
        check("long_accepts", accepts, 255);
        check("long_acc", longint'(acc_out), 267386880);
        handshake("long");

        // len=0 goes straight to DONE with zero
        start = 1'b1;
        len   = 8'd0;
        check("len0_ready_idle", longint'(in_ready), 0);
        step();
        start = 1'b0;
        check("len0_out_valid", longint'(out_valid), 1);
        check("len0_acc", longint'(acc_out), 0);
        check("len0_in_ready", longint'(in_ready), 0);
        handshake("len0");

        // Reset mid-run after two accepts
        start = 1'b1;
        len   = 8'd4;
        step();
        start    = 1'b0;
        a_data   = 14'sd1000;
        b_data   = 8'sd100;
        in_valid = 1'b1;
        step();
        step();
        #2 ap_rst = 1'b1;
        #1;
        check("mid_rst_idle", longint'(idle), 1);
        check("mid_rst_in_ready", longint'(in_ready), 0);
        check("mid_rst_out_valid", longint'(out_valid), 0);
        check("mid_rst_acc", longint'(acc_out), 0);
        in_valid = 1'b0;
        step();
        ap_rst = 1'b0;
        step();
        check("post_rst_idle", longint'(idle), 1);
        av = '0;
        bv = '0;
        av[0] = 14'sd3;
        bv[0] = -8'sd5;
        run_to_done(1, av, bv, "post_rst");
        check("post_rst_acc", longint'(acc_out), -15);
        handshake("post_rst");

        // Stall in DONE with start pulsed; start also coincides with the handshake
        av = '0;
        bv = '0;
        av[0] = 14'sd5; bv[0] = 8'sd6;
        av[1] = 14'sd7; bv[1] = 8'sd8;
        run_to_done(2, av, bv, "stall");
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 8'd3;
            step();
            if (!out_valid || acc_out != 30'sd86) stable = 1'b0;
        end
        start = 1'b0;
        check("stall_stable", longint'(stable), 1);
        check("stall_acc", longint'(acc_out), 86);
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start     = 1'b0;
        out_ready = 1'b0;
        check("stall_idle", longint'(idle), 1);
        step();
        check("stall_still_idle", longint'(idle), 1);
        check("stall_no_ready", longint'(in_ready), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
